// File: rtl/mem_load_align_if.sv
// Bundle of the load-request, memory-read and response channels of mem_load_align.
// The slave modport is the formatter's view. The master modport is the view of
// whatever drives requests, models the memory and consumes responses.
interface mem_load_align_if #(
  parameter int ADDR_W = 32
);
  // Load request channel.
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;

  // Data-memory read port.
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [31:0]       mem_rd_data;

  // Writeback response channel.
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_addr, req_size, req_unsigned, mem_rd_data, rsp_ready,
    output req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_size, req_unsigned, mem_rd_data, rsp_ready,
    input  req_ready, mem_rd_en, mem_rd_addr, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/mem_load_align.sv
// Load-data formatter between the data-memory read port and LSU writeback.
// It issues word-aligned reads, splits word-crossing loads into two reads when
// MISALIGN_EN=1, then extracts and extends the addressed bytes. The result is
// returned as a registered response.
module mem_load_align #(
  parameter bit MISALIGN_EN = 1'b1,
  parameter int ADDR_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_load_align_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  state_t            state_q;
  logic              rsp_valid_q;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic              split_q;
  logic [ADDR_W-1:0] word_q;
  logic [31:0]       lo_q;

  logic              accept;
  logic [1:0]        req_off;
  logic [ADDR_W-1:0] req_word;
  logic              is_err;
  logic              is_split;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;

  // The {hi,lo} pair is shifted down by the byte offset. Only the low byte,
  // half or word is kept, then extended.
  function automatic logic [31:0] format_load(input logic [31:0] hi,
                                              input logic [31:0] lo,
                                              input logic [1:0]  off,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic [31:0] sh;
    logic        sgn;
    sh = 32'({hi, lo} >> {off, 3'b000});
    case (size)
      SIZE_B: begin
        sgn = ~uns & sh[7];
        format_load = {{24{sgn}}, sh[7:0]};
      end
      SIZE_H: begin
        sgn = ~uns & sh[15];
        format_load = {{16{sgn}}, sh[15:0]};
      end
      default: format_load = sh;
    endcase
  endfunction

  assign req_off       = bus.req_addr[1:0];
  assign req_word      = {bus.req_addr[ADDR_W-1:2], 2'b00};
  assign bus.req_ready = (state_q == IDLE) && rst_n;
  assign accept        = bus.req_valid && bus.req_ready;

  // Classify the offered request as error, split or aligned.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    is_err   = 1'b0;
    is_split = 1'b0;
    case (bus.req_size)
      SIZE_B: ;
      SIZE_H: begin
        if (MISALIGN_EN) is_split = (req_off == 2'b11);
        else             is_err   = req_off[0];
      end
      SIZE_W: begin
        if (MISALIGN_EN) is_split = (req_off != 2'b00);
        else             is_err   = (req_off != 2'b00);
      end
      default: is_err = 1'b1;
    endcase
  end

  // The first read fires combinationally on acceptance. A split load's second
  // read fires from RD0 at the next word, wrapping modulo 2^ADDR_W.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (accept && !is_err) begin
      rd_en   = 1'b1;
      rd_addr = req_word;
    end else if (rst_n && (state_q == RD0) && split_q) begin
      rd_en   = 1'b1;
      rd_addr = word_q + ADDR_W'(4);
    end
  end

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_addr;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;

  // Load FSM: latch the request, collect one or two read words, then hold the response until it is taken.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      off_q       <= '0;
      size_q      <= '0;
      unsigned_q  <= 1'b0;
      split_q     <= 1'b0;
      word_q      <= '0;
      lo_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            off_q      <= req_off;
            size_q     <= bus.req_size;
            unsigned_q <= bus.req_unsigned;
            split_q    <= is_split;
            word_q     <= req_word;
            if (is_err) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state_q <= RD0;
            end
          end
        end
        RD0: begin
          if (split_q) begin
            lo_q    <= bus.mem_rd_data;
            state_q <= RD1;
          end else begin
            rsp_data_q  <= format_load(32'h0, bus.mem_rd_data, off_q, size_q, unsigned_q);
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RD1: begin
          rsp_data_q  <= format_load(bus.mem_rd_data, lo_q, off_q, size_q, unsigned_q);
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        default: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_load_align.sv
// Self-checking bench for mem_load_align. Two instances share one clock:
// dut_split (MISALIGN_EN=1) and dut_strict (MISALIGN_EN=0). sel_strict steers
// the stimulus to one of them. A byte-level reference model predicts every
// output on every cycle. Directed loads pin the model with literal values.
`timescale 1ns/1ps
module tb_mem_load_align;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus shared by both instances.
  logic        sel_strict;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_ready;
  logic [31:0] mem_rd_data;

  mem_load_align_if #(.ADDR_W(ADDR_W)) bus_split ();
  mem_load_align_if #(.ADDR_W(ADDR_W)) bus_strict ();

  mem_load_align #(.MISALIGN_EN(1'b1), .ADDR_W(ADDR_W)) dut_split (
    .clk(clk), .rst_n(rst_n), .bus(bus_split.slave));
  mem_load_align #(.MISALIGN_EN(1'b0), .ADDR_W(ADDR_W)) dut_strict (
    .clk(clk), .rst_n(rst_n), .bus(bus_strict.slave));

  assign bus_split.req_valid     = req_valid & ~sel_strict;
  assign bus_split.req_addr      = req_addr;
  assign bus_split.req_size      = req_size;
  assign bus_split.req_unsigned  = req_unsigned;
  assign bus_split.rsp_ready     = rsp_ready;
  assign bus_split.mem_rd_data   = mem_rd_data;
  assign bus_strict.req_valid    = req_valid & sel_strict;
  assign bus_strict.req_addr     = req_addr;
  assign bus_strict.req_size     = req_size;
  assign bus_strict.req_unsigned = req_unsigned;
  assign bus_strict.rsp_ready    = rsp_ready;
  assign bus_strict.mem_rd_data  = mem_rd_data;

  // Observed outputs of the selected instance. Reads are ORed so that a stray
  // read from the idle instance is also caught.
  logic        o_req_ready, o_rd_en, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rd_addr, o_rsp_data;
  assign o_req_ready = sel_strict ? bus_strict.req_ready : bus_split.req_ready;
  assign o_rd_en     = bus_strict.mem_rd_en | bus_split.mem_rd_en;
  assign o_rd_addr   = sel_strict ? bus_strict.mem_rd_addr : bus_split.mem_rd_addr;
  assign o_rsp_valid = sel_strict ? bus_strict.rsp_valid : bus_split.rsp_valid;
  assign o_rsp_data  = sel_strict ? bus_strict.rsp_data : bus_split.rsp_data;
  assign o_rsp_err   = sel_strict ? bus_strict.rsp_err : bus_split.rsp_err;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h4433_2211;
    if (a == 32'h0000_0104) return 32'h8877_6655;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return w[8*a[1:0] +: 8];
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_err(input logic [31:0] a, input logic [1:0] size, input bit strict);
    if (size == 2'b11) return 1'b1;
    return strict && ((a % nbytes(size)) != 0);
  endfunction

  function automatic bit ref_split(input logic [31:0] a, input logic [1:0] size);
    return (int'(a[1:0]) + nbytes(size)) > 4;
  endfunction

  // Gather the addressed bytes little-endian, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] size, input logic uns);
    int n;
    logic [31:0] v;
    n = nbytes(size);
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mem_byte(a + k);
    if (!uns && n < 4 && v[8*n-1])
      for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  // Memory: data answers a read one cycle later. Other cycles carry junk.
  logic [31:0] rd_log[$];
  initial begin
    logic        en_s;
    logic [31:0] addr_s;
    forever begin
      @(negedge clk);
      en_s   = o_rd_en;
      addr_s = o_rd_addr;
      if (en_s) rd_log.push_back(addr_s);
      @(posedge clk);
      #1;
      mem_rd_data = en_s ? mem_word(addr_s) : $urandom;
    end
  end

  // Compare process: predicts every output from the accepted request and the cycles elapsed since acceptance.
  bit          m_busy = 1'b0;
  int          m_t, m_lat;
  bit          m_split, m_err;
  logic [31:0] m_data, m_word;
  always @(negedge clk) begin
    bit e;
    if (!rst_n) begin
      check("rst_req_ready", 32'(o_req_ready), 32'd0);
      check("rst_rd_en", 32'(o_rd_en), 32'd0);
      m_busy = 1'b0;
    end else if (!m_busy) begin
      e = ref_err(req_addr, req_size, sel_strict);
      check("idle_req_ready", 32'(o_req_ready), 32'd1);
      check("idle_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("idle_rd_en", 32'(o_rd_en), 32'(req_valid && !e));
      if (req_valid && !e) check("rd0_addr", o_rd_addr, {req_addr[31:2], 2'b00});
      if (req_valid) begin
        m_busy  = 1'b1;
        m_t     = 0;
        m_err   = e;
        m_split = !e && ref_split(req_addr, req_size);
        m_lat   = e ? 1 : (m_split ? 3 : 2);
        m_data  = e ? 32'h0 : ref_load(req_addr, req_size, req_unsigned);
        m_word  = {req_addr[31:2], 2'b00};
      end
    end else begin
      m_t++;
      check("busy_req_ready", 32'(o_req_ready), 32'd0);
      check("busy_rd_en", 32'(o_rd_en), 32'(m_split && m_t == 1));
      if (m_split && m_t == 1) check("rd1_addr", o_rd_addr, m_word + 32'd4);
      check("rsp_valid", 32'(o_rsp_valid), 32'(m_t >= m_lat));
      if (m_t >= m_lat) begin
        check("rsp_data", o_rsp_data, m_data);
        check("rsp_err", 32'(o_rsp_err), 32'(m_err));
        if (rsp_ready) m_busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  // One load, entered at posedge+1 with both instances idle. Returns the
  // response and its latency in cycles from acceptance. hold>0 keeps rsp_ready low for hold valid cycles.
  task automatic do_load(input bit strict, input logic [31:0] a, input logic [1:0] sz,
                         input logic u, input int hold,
                         output logic [31:0] d, output logic e, output int lat);
    int guard;
    int t_acc;
    int nlog;
    sel_strict   = strict;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = u;
    rsp_ready    = (hold == 0);
    req_valid    = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!o_req_ready && guard < 20) begin @(negedge clk); guard++; end
    check("accept_timeout", 32'(o_req_ready), 32'd1);
    t_acc = cyc;
    @(posedge clk); #1;
    req_valid    = 1'b0;
    req_addr     = $urandom;
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom);
    guard = 0;
    @(negedge clk);
    while (!o_rsp_valid && guard < 20) begin @(negedge clk); guard++; end
    check("rsp_timeout", 32'(o_rsp_valid), 32'd1);
    lat  = cyc - t_acc;
    d    = o_rsp_data;
    e    = o_rsp_err;
    nlog = rd_log.size();
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        check("bp_valid", 32'(o_rsp_valid), 32'd1);
        check("bp_data", o_rsp_data, d);
        check("bp_req_ready", 32'(o_req_ready), 32'd0);
      end
      check("bp_no_reads", 32'(rd_log.size()), 32'(nlog));
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("rel_valid_hs", 32'(o_rsp_valid), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("rel_valid_low", 32'(o_rsp_valid), 32'd0);
      check("rel_req_ready", 32'(o_req_ready), 32'd1);
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 32'h0000_0100 + $urandom_range(0, 7);
      1:       return 32'hFFFF_FFF8 + $urandom_range(0, 7);
      2:       return 32'h0000_0000 + $urandom_range(0, 7);
      default: return $urandom;
    endcase
  endfunction

  // Random traffic for one instance, followed by a drain back to idle.
  task automatic rand_phase(input bit strict, input int cycles);
    sel_strict = strict;
    for (int i = 0; i < cycles; i++) begin
      req_valid    = ($urandom_range(0, 2) != 0);
      req_addr     = pick_addr();
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom);
      rsp_ready    = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    int          lat;
    int          seen;
    sel_strict   = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    req_size     = '0;
    req_unsigned = 1'b0;
    rsp_ready    = 1'b0;
    mem_rd_data  = '0;

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    check("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("reset_rsp_data", o_rsp_data, 32'd0);
    check("reset_rsp_err", 32'(o_rsp_err), 32'd0);
    check("reset_rd_addr", o_rd_addr, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte loads.
    rd_log.delete();
    do_load(1'b0, 32'h103, 2'b00, 1'b0, 0, d, e, lat);
    check("lb103_data", d, 32'h0000_0044);
    check("lb103_err", 32'(e), 32'd0);
    check("lb103_lat", 32'(lat), 32'd2);
    check("lb103_nreads", 32'(rd_log.size()), 32'd1);
    check("lb103_raddr", rd_log[0], 32'h100);
    do_load(1'b0, 32'h107, 2'b00, 1'b0, 0, d, e, lat);
    check("lb107_data", d, 32'hFFFF_FF88);
    do_load(1'b0, 32'h107, 2'b00, 1'b1, 0, d, e, lat);
    check("lbu107_data", d, 32'h0000_0088);

    // Half loads.
    do_load(1'b0, 32'h106, 2'b01, 1'b0, 0, d, e, lat);
    check("lh106_data", d, 32'hFFFF_8877);
    do_load(1'b0, 32'h106, 2'b01, 1'b1, 0, d, e, lat);
    check("lhu106_data", d, 32'h0000_8877);
    rd_log.delete();
    do_load(1'b0, 32'h102, 2'b01, 1'b0, 0, d, e, lat);
    check("lh102_data", d, 32'h0000_4433);
    check("lh102_nreads", 32'(rd_log.size()), 32'd1);

    // Split loads.
    rd_log.delete();
    do_load(1'b0, 32'h103, 2'b01, 1'b0, 0, d, e, lat);
    check("lh103_data", d, 32'h0000_5544);
    check("lh103_lat", 32'(lat), 32'd3);
    check("lh103_nreads", 32'(rd_log.size()), 32'd2);
    check("lh103_raddr0", rd_log[0], 32'h100);
    check("lh103_raddr1", rd_log[1], 32'h104);
    do_load(1'b0, 32'h101, 2'b10, 1'b0, 0, d, e, lat);
    check("lw101_data", d, 32'h5544_3322);

    // Errors.
    rd_log.delete();
    do_load(1'b1, 32'h101, 2'b10, 1'b0, 0, d, e, lat);
    check("strict_lw101_err", 32'(e), 32'd1);
    check("strict_lw101_data", d, 32'd0);
    check("strict_lw101_lat", 32'(lat), 32'd1);
    check("strict_lw101_nreads", 32'(rd_log.size()), 32'd0);
    do_load(1'b0, 32'h102, 2'b11, 1'b0, 0, d, e, lat);
    check("rsvd_err", 32'(e), 32'd1);
    check("rsvd_data", d, 32'd0);
    check("rsvd_lat", 32'(lat), 32'd1);
    check("rsvd_nreads", 32'(rd_log.size()), 32'd0);
    do_load(1'b1, 32'h102, 2'b01, 1'b1, 0, d, e, lat);
    check("strict_lh102_data", d, 32'h0000_4433);
    check("strict_lh102_err", 32'(e), 32'd0);

    // Address wrap, then backpressure.
    rd_log.delete();
    do_load(1'b0, 32'hFFFF_FFFE, 2'b10, 1'b0, 0, d, e, lat);
    check("wrap_nreads", 32'(rd_log.size()), 32'd2);
    check("wrap_raddr0", rd_log[0], 32'hFFFF_FFFC);
    check("wrap_raddr1", rd_log[1], 32'h0000_0000);
    do_load(1'b0, 32'h104, 2'b10, 1'b0, 5, d, e, lat);
    check("bp_lw104_data", d, 32'h8877_6655);

    // Reset during RD1 of a split load.
    sel_strict   = 1'b0;
    req_addr     = 32'h101;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    rsp_ready    = 1'b1;
    req_valid    = 1'b1;
    @(negedge clk);
    check("rst_test_accept", 32'(o_req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("midrst_rsp_data", o_rsp_data, 32'd0);
    check("midrst_rsp_err", 32'(o_rsp_err), 32'd0);
    check("midrst_rd_en", 32'(o_rd_en), 32'd0);
    check("midrst_rd_addr", o_rd_addr, 32'd0);
    check("midrst_req_ready", 32'(o_req_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_rsp_valid) seen++;
    end
    check("midrst_no_rsp", 32'(seen), 32'd0);
    @(posedge clk); #1;
    do_load(1'b0, 32'h104, 2'b10, 1'b0, 0, d, e, lat);
    check("post_rst_lw104", d, 32'h8877_6655);

    // Random traffic on both instances.
    rand_phase(1'b0, 3000);
    rand_phase(1'b1, 1000);
    rand_phase(1'b0, 500);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
